// File: rtl/bulk_line_axil_bridge.sv
// Memory-side slave of the cache's bulk line port: splits each line request into
// single-beat AXI-lite reads or writes and reassembles fills into a full line.
module bulk_line_axil_bridge #(
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 64,
    parameter int OFFSET_BITS    = 7,
    parameter int WORDS_PER_LINE = (1 << OFFSET_BITS) / (DATA_W / 8)
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          req_valid,
    output logic                                          req_ready,
    input  logic [ADDR_W-1:0]                             req_addr,
    input  logic                                          req_write,
    input  logic [WORDS_PER_LINE-1:0][DATA_W-1:0]         req_wdata,
    input  logic [WORDS_PER_LINE-1:0][DATA_W/8-1:0]       req_wstrb,
    output logic                                          resp_valid,
    output logic [WORDS_PER_LINE-1:0][DATA_W-1:0]         resp_rdata,
    output logic [ADDR_W-1:0]                             mem_araddr,
    output logic                                          mem_arvalid,
    input  logic                                          mem_arready,
    input  logic [DATA_W-1:0]                             mem_rdata,
    input  logic [1:0]                                    mem_rresp,
    input  logic                                          mem_rvalid,
    output logic                                          mem_rready,
    output logic [ADDR_W-1:0]                             mem_awaddr,
    output logic                                          mem_awvalid,
    input  logic                                          mem_awready,
    output logic [DATA_W-1:0]                             mem_wdata,
    output logic [DATA_W/8-1:0]                           mem_wstrb,
    output logic                                          mem_wvalid,
    input  logic                                          mem_wready,
    input  logic [1:0]                                    mem_bresp,
    input  logic                                          mem_bvalid,
    output logic                                          mem_bready,
    output logic                                          err
);

    localparam int BYTES = DATA_W / 8;
    localparam int BSH   = $clog2(BYTES);
    localparam int KW    = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'((1 << OFFSET_BITS) - 1);
    localparam logic [KW-1:0]     LAST_K    = KW'(WORDS_PER_LINE - 1);

    typedef enum logic [2:0] {IDLE, RD_AR, RD_R, RD_RESP, WR_AWW, WR_B} state_t;

    state_t                                  state_q, state_d;
    logic [KW-1:0]                           k_q;
    logic [ADDR_W-1:0]                       base_q;
    logic [WORDS_PER_LINE-1:0][DATA_W-1:0]   wbuf_q;
    logic [WORDS_PER_LINE-1:0][BYTES-1:0]    sbuf_q;
    logic [WORDS_PER_LINE-1:0][DATA_W-1:0]   rbuf_q;
    logic                                    aw_done_q, w_done_q;
    logic [ADDR_W-1:0]                       beat_addr;
    logic                                    last, skip, aw_ok, w_ok;

    assign beat_addr = base_q + (ADDR_W'(k_q) << BSH);
    assign last      = (k_q == LAST_K);
    // Beats with no enabled bytes never reach the bus.
    assign skip      = (state_q == WR_AWW) && (sbuf_q[k_q] == '0);
    assign aw_ok     = aw_done_q | (mem_awvalid & mem_awready);
    assign w_ok      = w_done_q  | (mem_wvalid  & mem_wready);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = req_write ? WR_AWW : RD_AR;
            RD_AR:   if (mem_arready) state_d = RD_R;
            RD_R:    if (mem_rvalid) state_d = last ? RD_RESP : RD_AR;
            RD_RESP: state_d = IDLE;
            WR_AWW: begin
                if (skip)               state_d = last ? IDLE : WR_AWW;
                else if (aw_ok && w_ok) state_d = WR_B;
            end
            WR_B:    if (mem_bvalid) state_d = last ? IDLE : WR_AWW;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready   = (state_q == IDLE);
        mem_arvalid = (state_q == RD_AR);
        mem_rready  = (state_q == RD_R);
        resp_valid  = (state_q == RD_RESP);
        mem_awvalid = (state_q == WR_AWW) && !skip && !aw_done_q;
        mem_wvalid  = (state_q == WR_AWW) && !skip && !w_done_q;
        mem_bready  = (state_q == WR_B);
        mem_araddr  = beat_addr;
        mem_awaddr  = beat_addr;
        mem_wdata   = wbuf_q[k_q];
        mem_wstrb   = sbuf_q[k_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_q        <= '0;
            base_q     <= '0;
            wbuf_q     <= '0;
            sbuf_q     <= '0;
            rbuf_q     <= '0;
            resp_rdata <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    base_q <= req_addr & ~LINE_MASK;
                    wbuf_q <= req_wdata;
                    sbuf_q <= req_wstrb;
                    k_q    <= '0;
                end
                RD_R: if (mem_rvalid) begin
                    rbuf_q[k_q] <= mem_rdata;
                    if (mem_rresp != 2'b00) err <= 1'b1;
                    // Publish the whole line together with the final word.
                    if (last) begin
                        for (int i = 0; i < WORDS_PER_LINE; i++)
                            resp_rdata[i] <= (KW'(i) == k_q) ? mem_rdata : rbuf_q[i];
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                WR_AWW: begin
                    if (skip) begin
                        if (!last) k_q <= k_q + KW'(1);
                    end else if (aw_ok && w_ok) begin
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end else begin
                        if (mem_awvalid && mem_awready) aw_done_q <= 1'b1;
                        if (mem_wvalid && mem_wready)   w_done_q  <= 1'b1;
                    end
                end
                WR_B: if (mem_bvalid) begin
                    if (mem_bresp != 2'b00) err <= 1'b1;
                    if (!last) k_q <= k_q + KW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
